// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Oversamples the synchronized rx line, recovers bytes LSB-first and buffers them for MMIO reads.
module uart_rx_fifo #(
  parameter int unsigned DELAY_FRAMES = 78,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int unsigned CNT_W     = $clog2(DELAY_FRAMES);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_OUT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]     HALF_M1 = CNT_W'(DELAY_FRAMES / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_M1 = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_OUT_W-1:0] DEPTH_C = CNT_OUT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxs;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [2:0]           r_bitn;
  logic [2:0]           w_bitn_nxt;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nxt;
  logic                 w_push;
  logic                 w_frame_set;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_OUT_W-1:0] r_count;
  logic                 r_overflow;
  logic                 r_frame_err;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic                 w_ovf_set;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bitn  <= w_bitn_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state: start bit checked at half period, data and stop at full periods.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bitn_nxt  = r_bitn;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt   = '0;
          w_bitn_nxt  = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt           = '0;
          w_shift_nxt[r_bitn] = w_rxs;
          if (r_bitn == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = rd_en && (r_count != '0);
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_OUT_W'(1);
        2'b01:   r_count <= r_count - CNT_OUT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign rd_valid  = (r_count != '0);
  assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clk/bit with a 4-entry FIFO.
// Frames are driven on negedges; outputs are sampled on negedges.
module tb_uart_rx_fifo;

  localparam int unsigned DF    = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       overflow;
  logic       frame_err;

  int n_checks;
  int n_err;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_fifo #(
    .DELAY_FRAMES(DF),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .overflow (overflow),
    .frame_err(frame_err),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Returns with the stop level still on the line; pop/clr pulses hit the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_s,
                            input logic clr_s);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = d[k];
      repeat (DF) @(negedge clk);
    end
    uart_rx = stop;
    for (int j = 0; j < int'(DF); j++) begin
      @(negedge clk);
      if (j == 5) begin
        rd_en   = pop_s;
        clr_err = clr_s;
      end
      if (j == 6) begin
        rd_en   = 1'b0;
        clr_err = 1'b0;
      end
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, 32'(rd_data), 32'(exp));
    pop();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;

    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_count: 1, exp_head: 8'h00, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_count: 1, exp_head: 8'hFF, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h80, stop: 1'b1, exp_count: 1, exp_head: 8'h80, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h01, stop: 1'b1, exp_count: 1, exp_head: 8'h01, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hA5, stop: 1'b0, exp_count: 0, exp_head: 8'h00, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'h6E, stop: 1'b1, exp_count: 1, exp_head: 8'h6E, exp_ferr: 1'b0};

    // Reset
    repeat (3) @(negedge clk);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1;
    idle(4);

    // Two back-to-back frames
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    uart_rx = 1'b1;
    check("rx2_count", 32'(count), 32'd2);
    check("rx2_head", 32'(rd_data), 32'h55);
    check("rx2_valid", 32'(rd_valid), 32'd1);
    @(negedge clk);
    pop();
    check("pop1_head", 32'(rd_data), 32'hA3);
    check("pop1_count", 32'(count), 32'd1);
    pop();
    check("pop2_count", 32'(count), 32'd0);
    idle(4);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
      idle(4);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_count > 0) begin
        check($sformatf("vec%0d_head", i), 32'(rd_data), 32'(vecs[i].exp_head));
      end
      for (int p = 0; p < vecs[i].exp_count; p++) pop();
      pulse_clr();
      idle(2);
    end

    // Glitch shorter than half a bit
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(10);
    check("glitch_count", 32'(count), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("post_glitch_head", 32'(rd_data), 32'h96);
    check("post_glitch_count", 32'(count), 32'd1);
    pop();
    idle(2);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    idle(4);
    check("frame_ferr", 32'(frame_err), 32'd1);
    check("frame_count", 32'(count), 32'd0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("after_break_count", 32'(count), 32'd1);
    check("after_break_head", 32'(rd_data), 32'h11);
    check("after_break_ferr", 32'(frame_err), 32'd1);
    pop();
    pulse_clr();
    check("clr_ferr", 32'(frame_err), 32'd0);
    check("clr_count", 32'(count), 32'd0);

    // Overflow; clr_err coincides with the dropping push so the set must win
    do_reset();
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag_set_wins", 32'(overflow), 32'd1);
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);
    pop_check("ovf_pop1", 8'h01);
    pop_check("ovf_pop2", 8'h02);
    send_frame(8'h06, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("wrap_count", 32'(count), 32'd4);
    pop_check("wrap_pop3", 8'h03);
    pop_check("wrap_pop4", 8'h04);
    pop_check("wrap_pop6", 8'h06);
    pop_check("wrap_pop7", 8'h07);
    check("wrap_empty_count", 32'(count), 32'd0);
    check("wrap_empty_valid", 32'(rd_valid), 32'd0);
    pop();
    check("underflow_count", 32'(count), 32'd0);
    check("underflow_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the stop-sample cycle
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b * 16), 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    check("cc_fill_count", 32'(count), 32'd4);
    send_frame(8'h50, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("cc_count", 32'(count), 32'd4);
    check("cc_ovf", 32'(overflow), 32'd0);
    pop_check("cc_pop1", 8'h20);
    pop_check("cc_pop2", 8'h30);
    pop_check("cc_pop3", 8'h40);
    pop_check("cc_pop4", 8'h50);
    check("cc_empty", 32'(count), 32'd0);

    // Reset in the middle of the data bits
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("pre_rst_count", 32'(count), 32'd1);
    uart_rx = 1'b0;
    repeat (DF) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DF) @(negedge clk);
    do_reset();
    idle(DF * 12);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_head", 32'(rd_data), 32'h5A);

    // Single entry with push and pop together
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("single_cc_count", 32'(count), 32'd1);
    check("single_cc_head", 32'(rd_data), 32'hC3);
    check("single_cc_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
